// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: boolean, transfer type,
// slave response encoding and the arbiter data-phase owner states.

package pkg_bool;

    typedef enum logic {
        False = 1'b0,
        True  = 1'b1
    } bool_e;

endpackage : pkg_bool

package pkg_trans;

    typedef enum logic {
        IDLE   = 1'b0,
        NONSEQ = 1'b1
    } trans_e;

endpackage : pkg_trans

package pkg_resp;

    localparam int unsigned RespWidth = 2;

    // Encoded as {resp, ready}
    typedef enum logic [RespWidth-1:0] {
        PENDING = 2'b00,
        SUCCESS = 2'b01
    } resp_e;

    function automatic logic resp_ready(input logic [RespWidth-1:0] code);
        return code[0];
    endfunction

endpackage : pkg_resp

package pkg_arb;

    localparam int unsigned NumMasters = 2;
    localparam int unsigned StateWidth = 2;

    // Data-phase owner: nobody, master 0 or master 1
    typedef enum logic [StateWidth-1:0] {
        StIdle  = 2'd0,
        StData0 = 2'd1,
        StData1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e data_state(input logic master);
        return master ? StData1 : StData0;
    endfunction

endpackage : pkg_arb

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: sole requester wins, contention goes to the
// master that was not granted last.

module rr_pick2
    import pkg_arb::*;
(
    input  logic [NumMasters-1:0] req_i,
    input  logic                  last_i,
    output logic [NumMasters-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = '0;
        endcase
    end

endmodule : rr_pick2

// File: rtl/mem_bus_arbiter.sv
// Two-master pipelined memory bus arbiter: zero-latency address-phase grant
// and data-phase read routing to the previous cycle's grantee.

module mem_bus_arbiter
    import pkg_bool::*;
    import pkg_trans::*;
    import pkg_resp::*;
    import pkg_arb::*;
#(
    parameter int unsigned DWidth = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_trans_i,
    input  logic              m0_write_i,
    input  logic [DWidth-1:0] m0_addr_i,
    input  logic [DWidth-1:0] m0_wdata_i,
    output logic [DWidth-1:0] m0_rdata_o,
    output logic              m0_resp_o,
    output logic              m0_ready_o,

    input  logic              m1_trans_i,
    input  logic              m1_write_i,
    input  logic [DWidth-1:0] m1_addr_i,
    input  logic [DWidth-1:0] m1_wdata_i,
    output logic [DWidth-1:0] m1_rdata_o,
    output logic              m1_resp_o,
    output logic              m1_ready_o,

    output logic              s_sel_o,
    output logic              s_trans_o,
    output logic              s_ready_o,
    output logic              s_write_o,
    output logic [DWidth-1:0] s_addr_o,
    output logic [DWidth-1:0] s_wdata_o,
    input  logic [DWidth-1:0] s_rdata_i,
    input  logic              s_resp_i,
    input  logic              s_ready_i
);

    arb_state_e            r_state;
    logic                  r_last_q;

    logic [NumMasters-1:0] w_req;
    logic [NumMasters-1:0] w_pick;
    logic [NumMasters-1:0] w_grant;
    logic                  w_slave_ready;
    logic                  w_grant_en;
    logic                  w_any_grant;
    logic                  w_in_reset;

    assign w_req[0]      = (m0_trans_i == NONSEQ);
    assign w_req[1]      = (m1_trans_i == NONSEQ);
    assign w_slave_ready = resp_ready({s_resp_i, s_ready_i});
    assign w_in_reset    = (rst_i == True);
    assign w_grant_en    = (w_slave_ready == True) && !w_in_reset;

    rr_pick2 u_rr_pick2 (
        .req_i   (w_req),
        .last_i  (r_last_q),
        .grant_o (w_pick)
    );

    assign w_grant     = w_grant_en ? w_pick : '0;
    assign w_any_grant = |w_grant;

    // Address phase: forward the granted master's request with no added latency
    always_comb begin
        s_sel_o    = 1'b0;
        s_trans_o  = IDLE;
        s_ready_o  = s_ready_i;
        s_write_o  = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        m0_ready_o = 1'b0;
        m1_ready_o = 1'b0;
        m0_resp_o  = 1'b0;
        m1_resp_o  = 1'b0;
        if (w_grant[0]) begin
            s_sel_o    = 1'b1;
            s_trans_o  = NONSEQ;
            s_ready_o  = 1'b1;
            s_write_o  = m0_write_i;
            s_addr_o   = m0_addr_i;
            s_wdata_o  = m0_wdata_i;
            m0_ready_o = 1'b1;
            m0_resp_o  = s_resp_i;
        end else if (w_grant[1]) begin
            s_sel_o    = 1'b1;
            s_trans_o  = NONSEQ;
            s_ready_o  = 1'b1;
            s_write_o  = m1_write_i;
            s_addr_o   = m1_addr_i;
            s_wdata_o  = m1_wdata_i;
            m1_ready_o = 1'b1;
            m1_resp_o  = s_resp_i;
        end
    end

    // Data phase: read data goes only to the owner; reset drops it
    always_comb begin
        m0_rdata_o = '0;
        m1_rdata_o = '0;
        if (!w_in_reset) begin
            if (r_state == StData0) m0_rdata_o = s_rdata_i;
            if (r_state == StData1) m1_rdata_o = s_rdata_i;
        end
    end

    // Owner/priority registers; a stalled slave freezes both
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_last_q <= 1'b1;
        end else if (w_slave_ready) begin
            if (w_any_grant) begin
                r_state  <= data_state(w_grant[1]);
                r_last_q <= w_grant[1];
            end else begin
                r_state  <= StIdle;
            end
        end
    end

endmodule : mem_bus_arbiter
